// File: rtl/ahb_bus_arbiter.sv
// Two-requester AHB-Lite front end: arbitrates fetch vs load/store and runs one
// non-pipelined word transfer at a time (address phase, data phase, response).
module ahb_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LS_PRIORITY = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_write,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t              state, state_nx;
    logic                owner_ls;
    logic                last_ls;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CNT_W-1:0]    wait_cnt;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                any_req;
    logic                grant_ls;
    logic                timeout_hit;
    logic                unused_addr_lsb;

    assign any_req = if_req | ls_req;

    // Ties go to load/store in priority mode, otherwise to whoever did not own the bus last.
    always_comb begin
        grant_ls = 1'b0;
        if (ls_req && !if_req)
            grant_ls = 1'b1;
        else if (ls_req && if_req)
            grant_ls = (LS_PRIORITY != 0) ? 1'b1 : !last_ls;
    end

    // wait_cnt counts wait cycles already tolerated; the (TIMEOUT+1)th wait forces an error.
    assign timeout_hit = (TIMEOUT != 0) && !HREADY && (wait_cnt == CNT_W'(TIMEOUT));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = ADDR;
            ADDR:    if (HREADY) state_nx = DATA;
            DATA:    if (HREADY || timeout_hit) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner_ls <= 1'b0;
            last_ls  <= 1'b1;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_ls <= grant_ls;
                        last_ls  <= grant_ls;
                        addr_q   <= grant_ls ? ls_addr : if_addr;
                        wr_q     <= grant_ls & ls_write;
                        wdata_q  <= (grant_ls && ls_write) ? ls_wdata : '0;
                    end
                end
                ADDR: wait_cnt <= '0;
                DATA: begin
                    if (HREADY) begin
                        rdata_q <= HRDATA;
                        err_q   <= HRESP;
                    end else if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus and completion outputs are pure decodes of the state plus latched request.
    assign HTRANS  = (state == ADDR) ? 2'b10 : 2'b00;
    assign HADDR   = {addr_q[ADDR_W-1:2], 2'b00};
    assign HWRITE  = (state == ADDR) && wr_q;
    assign HSIZE   = 3'b010;
    assign HWDATA  = (state == DATA) ? wdata_q : '0;
    assign if_done = (state == RESP) && !owner_ls;
    assign ls_done = (state == RESP) && owner_ls;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign busy    = (state != IDLE);

    assign unused_addr_lsb = &{1'b0, addr_q[1:0]};

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench: directed vector table, tie/round-robin and reset corner
// sequences, and randomized transactions against a transaction-level model.
module tb_ahb_bus_arbiter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_write;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [31:0] HRDATA;
    logic        HREADY, HRESP;

    logic        if_done, ls_done, err, busy, HWRITE;
    logic [31:0] rdata, HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;

    logic        b_if_req, b_ls_req;
    logic        b_if_done, b_ls_done, b_err, b_busy, b_HWRITE;
    logic [31:0] b_rdata, b_HADDR, b_HWDATA;
    logic [1:0]  b_HTRANS;
    logic [2:0]  b_HSIZE;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LS_PRIORITY(1), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .ls_req(ls_req), .ls_write(ls_write), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done),
        .rdata(rdata), .err(err), .busy(busy),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    ahb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .LS_PRIORITY(0), .TIMEOUT(TMO)) dut_rr (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(if_addr), .if_done(b_if_done),
        .ls_req(b_ls_req), .ls_write(ls_write), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(b_ls_done),
        .rdata(b_rdata), .err(b_err), .busy(b_busy),
        .HADDR(b_HADDR), .HTRANS(b_HTRANS), .HWRITE(b_HWRITE), .HSIZE(b_HSIZE), .HWDATA(b_HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    typedef struct {
        bit          ls;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] hrd;
        bit          hresp;
        int          aw;
        int          dw;
        logic [31:0] e_haddr;
        int          e_done;
        logic [31:0] e_rdata;
        bit          e_err;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one granted transfer starting in the IDLE cycle (c=0) where the request is
    // sampled. aw/dw are the HREADY=0 cycles the slave inserts in ADDR and DATA.
    task automatic run_txn(input bit w_ls, input logic [31:0] e_haddr, input bit e_wr,
                           input logic [31:0] e_wdata, input logic [31:0] hrd, input bit hresp,
                           input int aw, input int dw, input int e_done,
                           input logic [31:0] e_rdata, input bit e_err);
        int d0;
        d0 = aw + 2;
        for (int c = 0; c <= e_done; c++) begin
            HREADY = (c == 0) || (c == aw + 1) || (c == d0 + dw);
            HRESP  = hresp && ((c == d0 + dw) || (dw > 0 && c == d0 + dw - 1));
            HRDATA = (c == d0 + dw) ? hrd : $urandom;
            @(negedge clk);
            check("htrans", 32'(HTRANS), (c >= 1 && c <= aw + 1) ? 32'h2 : 32'h0);
            check("busy", 32'(busy), 32'(c != 0));
            check("hsize", 32'(HSIZE), 32'h2);
            if (c >= 1 && c <= aw + 1) begin
                check("haddr", HADDR, e_haddr);
                check("hwrite_addr", 32'(HWRITE), 32'(e_wr));
            end
            if (c >= d0 && c < e_done) begin
                check("hwdata", HWDATA, e_wdata);
                check("hwrite_data", 32'(HWRITE), 32'h0);
            end
            check("if_done", 32'(if_done), 32'(c == e_done && !w_ls));
            check("ls_done", 32'(ls_done), 32'(c == e_done && w_ls));
            if (c == e_done) begin
                check("rdata", rdata, e_rdata);
                check("err", 32'(err), 32'(e_err));
            end
            step();
            if (c == 0) begin
                // granted request is latched; the owner's inputs may now wander
                if (w_ls) begin
                    ls_addr  = $urandom;
                    ls_wdata = $urandom;
                    ls_write = ~ls_write;
                end else begin
                    if_addr = $urandom;
                end
            end
            if (c == e_done) begin
                if (w_ls) ls_req = 1'b0;
                else      if_req = 1'b0;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          pend_if, pend_ls, w_ls, wr, tmo, hresp;
        logic [31:0] addr, wd, hrd;
        int          aw, dw, wait_eff;

        tbl[0] = '{0, 1, 32'h0000_0100, 32'hAAAA_5555, 32'hDEAD_BEEF, 0, 0, 0,  32'h0000_0100, 3,  32'hDEAD_BEEF, 0};
        tbl[1] = '{1, 1, 32'h0000_2003, 32'h1234_5678, 32'h0BAD_F00D, 0, 0, 2,  32'h0000_2000, 5,  32'h0BAD_F00D, 0};
        tbl[2] = '{1, 0, 32'h0000_3004, 32'h0,         32'h1111_2222, 1, 0, 1,  32'h0000_3004, 4,  32'h1111_2222, 1};
        tbl[3] = '{1, 0, 32'h0000_0040, 32'h0,         32'h0000_5555, 0, 0, 20, 32'h0000_0040, 19, 32'h0,         1};
        tbl[4] = '{0, 0, 32'h0000_07FC, 32'h0,         32'hCAFE_F00D, 0, 0, 16, 32'h0000_07FC, 19, 32'hCAFE_F00D, 0};
        tbl[5] = '{1, 1, 32'hFFFF_FFFE, 32'h0F0F_0F0F, 32'h0000_0001, 1, 2, 0,  32'hFFFF_FFFC, 5,  32'h0000_0001, 1};
        tbl[6] = '{0, 0, 32'h1234_5679, 32'h0,         32'h600D_CAFE, 0, 1, 3,  32'h1234_5678, 7,  32'h600D_CAFE, 0};

        rst = 1'b1;
        if_req = 0; ls_req = 0; ls_write = 0; b_if_req = 0; b_ls_req = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0;
        HRDATA = 0; HREADY = 1; HRESP = 0;
        step();
        step();
        @(negedge clk);
        check("rst_htrans", 32'(HTRANS), 32'h0);
        check("rst_hwrite", 32'(HWRITE), 32'h0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_hsize", 32'(HSIZE), 32'h2);
        check("rst_if_done", 32'(if_done), 32'h0);
        check("rst_ls_done", 32'(ls_done), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        step();
        rst = 1'b0;

        // directed vector table
        foreach (tbl[i]) begin
            ls_write = tbl[i].wr;
            ls_wdata = tbl[i].wdata;
            if (tbl[i].ls) begin
                ls_req  = 1'b1;
                ls_addr = tbl[i].addr;
            end else begin
                if_req  = 1'b1;
                if_addr = tbl[i].addr;
            end
            run_txn(tbl[i].ls, tbl[i].e_haddr, tbl[i].ls && tbl[i].wr,
                    (tbl[i].ls && tbl[i].wr) ? tbl[i].wdata : 32'h0, tbl[i].hrd, tbl[i].hresp,
                    tbl[i].aw, tbl[i].dw, tbl[i].e_done, tbl[i].e_rdata, tbl[i].e_err);
        end

        // simultaneous requests, load/store priority: LS first, fetch in the IDLE after ls_done
        if_req = 1'b1; if_addr = 32'h0000_0300;
        ls_req = 1'b1; ls_addr = 32'h0000_0404; ls_write = 1'b0;
        run_txn(1, 32'h0000_0404, 0, 32'h0, 32'h0000_0077, 0, 0, 0, 3, 32'h0000_0077, 0);
        run_txn(0, 32'h0000_0300, 0, 32'h0, 32'h0000_0088, 0, 0, 0, 3, 32'h0000_0088, 0);

        // round-robin instance: held ties alternate IF, LS, IF, LS starting from reset
        if_addr = 32'h0000_0800; ls_addr = 32'h0000_0900; ls_write = 1'b1; ls_wdata = 32'h0000_0042;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hC0DE_0001;
        b_if_req = 1'b1; b_ls_req = 1'b1;
        for (int c = 0; c < 16; c++) begin
            bit own_ls;
            own_ls = ((c / 4) % 2) == 1;
            @(negedge clk);
            check("rr_busy", 32'(b_busy), 32'(c % 4 != 0));
            check("rr_hsize", 32'(b_HSIZE), 32'h2);
            check("rr_htrans", 32'(b_HTRANS), (c % 4 == 1) ? 32'h2 : 32'h0);
            if (c % 4 == 1) begin
                check("rr_haddr", b_HADDR, own_ls ? 32'h0000_0900 : 32'h0000_0800);
                check("rr_hwrite", 32'(b_HWRITE), 32'(own_ls));
            end
            if (c % 4 == 2) check("rr_hwdata", b_HWDATA, own_ls ? 32'h0000_0042 : 32'h0);
            check("rr_if_done", 32'(b_if_done), 32'(c % 4 == 3 && !own_ls));
            check("rr_ls_done", 32'(b_ls_done), 32'(c % 4 == 3 && own_ls));
            if (c % 4 == 3) begin
                check("rr_rdata", b_rdata, 32'hC0DE_0001);
                check("rr_err", 32'(b_err), 32'h0);
            end
            step();
        end
        b_if_req = 1'b0; b_ls_req = 1'b0;
        ls_write = 1'b0;

        // reset asserted in DATA: abort without a done pulse, then a fresh request completes
        ls_req = 1'b1; ls_addr = 32'h0000_0500; ls_write = 1'b1; ls_wdata = 32'h0000_0099;
        @(negedge clk);
        step();
        HREADY = 1'b1;
        @(negedge clk);
        check("rstd_htrans_addr", 32'(HTRANS), 32'h2);
        step();
        HREADY = 1'b0;
        @(negedge clk);
        check("rstd_busy_data", 32'(busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ls_req = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rstd_htrans", 32'(HTRANS), 32'h0);
            check("rstd_busy", 32'(busy), 32'h0);
            check("rstd_ls_done", 32'(ls_done), 32'h0);
            check("rstd_if_done", 32'(if_done), 32'h0);
            check("rstd_rdata", rdata, 32'h0);
            step();
        end
        ls_req = 1'b1; ls_addr = 32'h0000_0504; ls_write = 1'b0;
        run_txn(1, 32'h0000_0504, 0, 32'h0, 32'h0000_ABCD, 0, 0, 0, 3, 32'h0000_ABCD, 0);

        // randomized transfers against a transaction-level model
        pend_if = 1'b0; pend_ls = 1'b0;
        for (int it = 0; it < 150; it++) begin
            if (!pend_if && $urandom_range(1, 0) == 1) begin
                if_req = 1'b1; if_addr = $urandom; pend_if = 1'b1;
            end
            if (!pend_ls && $urandom_range(1, 0) == 1) begin
                ls_req = 1'b1; ls_addr = $urandom; ls_write = 1'($urandom); ls_wdata = $urandom;
                pend_ls = 1'b1;
            end
            if (!pend_if && !pend_ls) begin
                if_req = 1'b1; if_addr = $urandom; pend_if = 1'b1;
            end
            w_ls  = pend_ls;
            wr    = w_ls && ls_write;
            addr  = (w_ls ? ls_addr : if_addr) & 32'hFFFF_FFFC;
            wd    = wr ? ls_wdata : 32'h0;
            aw    = $urandom_range(2, 0);
            dw    = ($urandom_range(7, 0) == 0) ? $urandom_range(18, 14) : $urandom_range(3, 0);
            hresp = ($urandom_range(3, 0) == 0);
            hrd   = $urandom;
            tmo   = dw > TMO;
            wait_eff = tmo ? TMO : dw;
            run_txn(w_ls, addr, wr, wd, hrd, hresp, aw, dw, aw + 2 + wait_eff + 1,
                    tmo ? 32'h0 : hrd, tmo ? 1'b1 : hresp);
            if (w_ls) pend_ls = 1'b0;
            else      pend_if = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
